// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, handles
// stall/flush/redirect from the hazard unit and writeback, and keeps fetch/stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus8_q, pc_plus8_d;
  logic        valid_q, valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] pc_plus4_f;

  assign pc_plus4_f = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4_f;
    if (PCSrcW)
      pc_d = {ResultW[31:2], 2'b00};
    else if (StallF)
      pc_d = pc_q;
  end

  // Flush beats stall so a redirect bubble is never lost behind a decode stall.
  always_comb begin
    instr_d     = instr_q;
    valid_d     = valid_q;
    pc_plus8_d  = pc_plus8_q;
    fetch_cnt_d = fetch_cnt_q;
    if (FlushD) begin
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      pc_plus8_d = pc_plus4_f + 32'd4;
    end else if (!StallD) begin
      instr_d     = InstrF;
      valid_d     = 1'b1;
      pc_plus8_d  = pc_plus4_f + 32'd4;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // Stall cycles count even when a redirect overrides the hold.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      pc_plus8_q  <= RESET_PC + 32'd8;
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      pc_plus8_q  <= pc_plus8_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PCF        = pc_q;
  assign InstrD     = instr_q;
  assign ValidD     = valid_q;
  assign PCPlus8D   = pc_plus8_q;
  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async reset
// sequence, then randomized control against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcW;
  logic [31:0] ResultW, InstrF;
  logic [31:0] PCF, InstrD, PCPlus8D, FetchCount, StallCount;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcW(PCSrcW), .ResultW(ResultW), .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD),
    .PCPlus8D(PCPlus8D), .ValidD(ValidD), .FetchCount(FetchCount), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'h1000 + (addr >> 2);
  endfunction

  assign InstrF = imem(PCF);

  typedef struct {
    logic        stf, std, fld, src;
    logic [31:0] res;
    logic [31:0] pc, instr;
    logic        valid;
    logic [31:0] p8, fc, sc;
  } vec_t;

  vec_t vecs[20];

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_p8, m_fc, m_sc;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                         input logic valid, input logic [31:0] p8,
                         input logic [31:0] fc, input logic [31:0] sc);
    chk({tag, ".PCF"}, PCF, pc);
    chk({tag, ".InstrD"}, InstrD, instr);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, valid});
    chk({tag, ".PCPlus8D"}, PCPlus8D, p8);
    chk({tag, ".FetchCount"}, FetchCount, fc);
    chk({tag, ".StallCount"}, StallCount, sc);
  endtask

  task automatic drive(input logic stf, input logic std, input logic fld,
                       input logic src, input logic [31:0] res);
    StallF = stf; StallD = std; FlushD = fld; PCSrcW = src; ResultW = res;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_p8 = 32'h8; m_fc = 0; m_sc = 0;
  endtask

  task automatic model_edge();
    logic [31:0] cur_pc;
    cur_pc = m_pc;
    if (PCSrcW)      m_pc = ResultW & 32'hFFFF_FFFC;
    else if (!StallF) m_pc = cur_pc + 4;
    if (FlushD) begin
      m_instr = NOP; m_valid = 1'b0; m_p8 = cur_pc + 8;
    end else if (!StallD) begin
      m_instr = imem(cur_pc); m_valid = 1'b1; m_p8 = cur_pc + 8; m_fc = m_fc + 1;
    end
    if (StallF) m_sc = m_sc + 1;
  endtask

  initial begin
    //          stf std fld src res           pc            instr         v  p8            fc  sc
    vecs[0]  = '{0, 0, 0, 0, 32'h0,          32'h4,        32'h1000,     1, 32'h8,        1,  0};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,          32'h8,        32'h1001,     1, 32'hC,        2,  0};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,          32'hC,        32'h1002,     1, 32'h10,       3,  0};
    vecs[3]  = '{0, 0, 0, 0, 32'h0,          32'h10,       32'h1003,     1, 32'h14,       4,  0};
    vecs[4]  = '{1, 1, 0, 0, 32'h0,          32'h10,       32'h1003,     1, 32'h14,       4,  1};
    vecs[5]  = '{1, 1, 0, 0, 32'h0,          32'h10,       32'h1003,     1, 32'h14,       4,  2};
    vecs[6]  = '{1, 1, 0, 0, 32'h0,          32'h10,       32'h1003,     1, 32'h14,       4,  3};
    vecs[7]  = '{0, 0, 0, 0, 32'h0,          32'h14,       32'h1004,     1, 32'h18,       5,  3};
    vecs[8]  = '{0, 0, 0, 0, 32'h0,          32'h18,       32'h1005,     1, 32'h1C,       6,  3};
    vecs[9]  = '{1, 0, 1, 1, 32'h203,        32'h200,      NOP,          0, 32'h20,       6,  4};
    vecs[10] = '{0, 0, 0, 0, 32'h0,          32'h204,      32'h1080,     1, 32'h208,      7,  4};
    vecs[11] = '{0, 1, 1, 0, 32'h0,          32'h208,      NOP,          0, 32'h20C,      7,  4};
    vecs[12] = '{0, 0, 0, 0, 32'h0,          32'h20C,      32'h1082,     1, 32'h210,      8,  4};
    vecs[13] = '{0, 0, 1, 1, 32'hFFFFFFFF,   32'hFFFFFFFC, NOP,          0, 32'h214,      8,  4};
    vecs[14] = '{0, 0, 0, 0, 32'h0,          32'h0,        32'h40000FFF, 1, 32'h4,        9,  4};
    vecs[15] = '{0, 0, 0, 0, 32'h0,          32'h4,        32'h1000,     1, 32'h8,        10, 4};
    vecs[16] = '{0, 0, 0, 1, 32'h100,        32'h100,      32'h1001,     1, 32'hC,        11, 4};
    vecs[17] = '{0, 0, 0, 0, 32'h0,          32'h104,      32'h1040,     1, 32'h108,      12, 4};
    vecs[18] = '{0, 1, 0, 0, 32'h0,          32'h108,      32'h1040,     1, 32'h108,      12, 4};
    vecs[19] = '{1, 0, 0, 0, 32'h0,          32'h108,      32'h1042,     1, 32'h110,      13, 5};

    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    #2;
    chk_all("reset", 32'h0, NOP, 1'b0, 32'h8, 32'h0, 32'h0);
    #5 reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].stf, vecs[i].std, vecs[i].fld, vecs[i].src, vecs[i].res);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].valid,
              vecs[i].p8, vecs[i].fc, vecs[i].sc);
    end

    // async reset in the middle of a stall, with a redirect pending
    drive(1, 1, 0, 0, 32'h0);
    @(posedge clk); #1;
    drive(1, 1, 0, 1, 32'h400);
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, NOP, 1'b0, 32'h8, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk_all("rst_held", 32'h0, NOP, 1'b0, 32'h8, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk_all("post_rst0", 32'h4, 32'h1000, 1'b1, 32'h8, 32'h1, 32'h0);
    @(posedge clk); #1;
    chk_all("post_rst1", 32'h8, 32'h1001, 1'b1, 32'hC, 32'h2, 32'h0);

    // randomized control against the behavioural model
    reset = 1'b1;
    #1;
    model_reset();
    #2 reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom);
      model_edge();
      @(posedge clk); #1;
      chk_all($sformatf("rand%0d", n), m_pc, m_instr, m_valid, m_p8, m_fc, m_sc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined ARM core; directly upstream of the decode/controller stage.
- Owns the program counter, drives the instruction-memory address, and registers the fetched instruction and PC+8 into Decode.
- Honours stall and flush requests from the hazard unit.
- Accepts the Writeback-stage PC redirect (PCSrcW/ResultW).
- Keeps two performance counters.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'hE1A00000, bubble instruction injected into Decode on reset/flush (MOV R0,R0, cond AL).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- StallF  in  1  hold PC.
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  replace IF/ID contents with bubble.
- PCSrcW  in  1  Writeback redirects PC.
- ResultW  in  32  redirect target.
- InstrF  in  32  instruction-memory read data (combinational from PCF).
- PCF  out  32  instruction-memory address.
- InstrD  out  32  instruction to Decode; [31:12] feeds the controller.
- PCPlus8D  out  32  PC+8 of InstrD (R15 read value).
- ValidD  out  1  InstrD is a real fetched instruction (0 = bubble).
- FetchCount  out  32  count of instructions accepted into Decode.
- StallCount  out  32  count of cycles with StallF=1.

Behaviour:
- Reset (async, immediate, no clock edge required):
  - PCF=RESET_PC
  - InstrD=NOP_INSTR, ValidD=0, PCPlus8D=RESET_PC+8
  - FetchCount=0, StallCount=0
- PCPlus4F = PCF+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- PC next-value priority, evaluated each rising edge:
  1. PCSrcW=1: PCF <= {ResultW[31:2],2'b00}. Redirect wins over StallF.
  2. StallF=1: PCF holds.
  3. Otherwise: PCF <= PCPlus4F.
- IF/ID register priority, evaluated each rising edge:
  1. FlushD=1: InstrD<=NOP_INSTR, ValidD<=0, PCPlus8D<=PCPlus4F+4. Flush wins over StallD.
  2. StallD=1: InstrD, ValidD and PCPlus8D all hold.
  3. Otherwise: InstrD<=InstrF, ValidD<=1, PCPlus8D<=PCPlus4F+4, modulo 2^32.
- Fetch latency: instruction at address A appears on InstrD one cycle after PCF=A, provided neither FlushD nor StallD is active on that edge.
- PCSrcW without FlushD: the wrong-path instruction still enters Decode. The hazard unit asserts FlushD alongside PCSrcW; this block does not flush on its own.
- After a redirect edge, PCF=target. The target instruction reaches InstrD on the following edge.
- FetchCount increments by 1 on each edge where the IF/ID register loads (not flushed, not stalled). Wraps 0xFFFFFFFF -> 0.
- StallCount increments by 1 on each edge where StallF=1, including edges where PCSrcW overrides the stall. Wraps 0xFFFFFFFF -> 0.
- Reset mid-operation: all state returns to reset values immediately. An in-flight redirect or stall is discarded. The first edge after reset deassertion follows the normal rules from RESET_PC.
- The block does not check InstrF for X/validity.

Test Plan:
- Reset then free-run with imem[i]=0x1000+i and no stall/flush:
  - PCF = 0,4,8,C on successive edges.
  - InstrD = 0x1000, 0x1001, ... one cycle behind PCF.
  - PCPlus8D = PC+8 of each instruction.
  - ValidD=1 from the first edge; FetchCount=4 after 4 edges.
- StallF=StallD=1 for 3 cycles at PCF=0x10:
  - PCF, InstrD and PCPlus8D hold.
  - StallCount=3 and FetchCount unchanged.
  - Normal sequencing resumes at 0x14 on release.
- PCSrcW=1, ResultW=0x00000203, FlushD=1 in the same cycle, with StallF=1:
  - Next edge: PCF=0x200, InstrD=0xE1A00000, ValidD=0.
  - Following edge: InstrD=imem[0x200].
- FlushD=1 with StallD=1: bubble is loaded (flush wins), ValidD=0, FetchCount unchanged.
- Set PC to 0xFFFFFFFC via redirect, then free-run: PCF wraps to 0x00000000; PCPlus8D for 0xFFFFFFFC equals 0x00000004.
- Assert reset asynchronously mid-cycle during a stall:
  - PCF=RESET_PC, InstrD=NOP_INSTR, ValidD=0 and both counters=0 before the next clock edge.
  - Normal fetch resumes after deassertion.
